dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Data-memory and load/store stage sitting directly downstream of the single-cycle RV32I core.
- Consumes the core's 12-bit ALU byte address, store data (rs2), load/store strobes and funct3.
- Returns the formatted load value to the core's write-back input.
- Owns byte-lane store masking, load sign/zero extension, misalignment detection, a sticky fault flag, and a small MMIO window: tohost/halt register and cycle counter.

Parameters:
- ADDR_W, 12, byte-address width; matches the core's ALU address output.
- DEPTH, 1024, RAM depth in 32-bit words; must equal 2^(ADDR_W-2).
- TOHOST_ADDR, 12'hFFC, word-aligned MMIO address of the tohost register.
- CYCLE_ADDR, 12'hFF8, word-aligned MMIO address of the read-only cycle counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted
- i_addr  in  ADDR_W  byte address (core ALU result)
- i_wdata  in  32  store data (core rs2 value)
- i_ld  in  1  load strobe (core mem_to_reg)
- i_sw  in  1  store strobe (core mem_write)
- i_funct3  in  3  instr[14:12]
- o_rdata  out  32  formatted load data to core write-back
- o_misalign  out  1  combinational: current access is misaligned
- o_fault  out  1  sticky registered misalign/illegal-width flag
- o_halt  out  1  registered; set by a store to TOHOST_ADDR
- o_tohost  out  32  value captured by the halting store

Behaviour:
- Reset (reset=0, async): o_fault=0, o_halt=0, o_tohost=0, cycle counter=0. RAM contents are not reset. o_rdata and o_misalign are combinational.
- Word index = i_addr[ADDR_W-1:2]; lane = i_addr[1:0].
- Loads: combinational read, zero-cycle latency.
  - LB/LBU: byte at lane; sign/zero-extend.
  - LH/LHU: halfword at i_addr[1]; misaligned if i_addr[0]=1.
  - LW: misaligned if lane != 0.
  - funct3 3, 6 or 7 is an illegal width.
  - Misaligned or illegal load: o_rdata=0.
  - o_rdata=0 whenever i_ld=0.
- Stores: write on posedge clk.
  - SB: mask = 1<<lane; byte replicated on all lanes.
  - SH: mask 0011 or 1100; halfword replicated.
  - SW: mask 1111.
  - funct3 >= 3 is an illegal width.
  - Misaligned or illegal store writes nothing.
- o_misalign = (i_ld|i_sw) & (misaligned | illegal width).
- o_fault: set on any posedge where o_misalign=1; cleared only by reset.
- i_ld and i_sw both high: the store executes, the load is ignored (o_rdata=0). o_misalign is evaluated on the store's width.
- Halt:
  - An SW to TOHOST_ADDR while o_halt=0 sets o_tohost<=i_wdata and o_halt<=1, effective the next cycle.
  - While o_halt=1, every store is suppressed (RAM and MMIO), the counter freezes, and loads still work.
  - SB/SH to TOHOST_ADDR are ignored and are not faults.
- Cycle counter:
  - 32-bit, increments every cycle while o_halt=0; wraps FFFFFFFF->0.
  - An LW at CYCLE_ADDR returns the pre-increment value of that cycle.
  - Stores to CYCLE_ADDR are dropped.
- An LW at TOHOST_ADDR returns o_tohost.
- MMIO addresses shadow the RAM words they alias; those RAM words are never written.

Optional Feature:
- Macro DMEM_MMIO_EN.
- Defined: tohost, halt and cycle-counter behaviour as above.
- Undefined: TOHOST_ADDR and CYCLE_ADDR are ordinary RAM words; o_halt and o_tohost are tied to 0; no counter flops exist. Stores are never halt-suppressed.

Decomposition:
- Package dmem_pkg: funct3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5), default TOHOST/CYCLE addresses, lane-mask width constant.
- Sub-module dmem_load_fmt: purely combinational lane extraction and sign/zero extension. Inputs are the raw word, lane and funct3; outputs are the formatted data and a misalign/illegal flag.
- Store masking, RAM, MMIO and the fault flag stay in dmem_lsu.

Test Plan:
- SW 0x8899AABB @0x010, then LB @0x011 -> 0xFFFFFFAA; LBU @0x011 -> 0x000000AA; LH @0x012 -> 0xFFFF8899; LW @0x010 -> 0x8899AABB.
- SW 0 @0x020; SB 0x5A @0x023; SH 0x1234 @0x020 -> LW @0x020 = 0x5A001234.
- SW 0xDEADBEEF @0x031 -> o_misalign=1 that cycle, RAM word 0x030 unchanged, o_fault=1 next cycle and held until reset; LH @0x013 -> o_rdata=0, o_misalign=1.
- [DMEM_MMIO_EN] SW 0x00000001 @0xFFC -> next cycle o_halt=1, o_tohost=1; subsequent SW 0x77 @0x040 leaves the word unchanged; LW @0xFF8 on two cycles returns equal values.
- Counter forced to 0xFFFFFFFF, one clock -> LW @0xFF8 = 0; assert reset mid-run -> o_halt, o_fault, o_tohost and the counter clear immediately (async), while previously written RAM data is retained.
- i_ld=1 and i_sw=1 together with SW 0xCAFEF00D @0x050 -> o_rdata=0, write occurs; next LW @0x050 = 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory / load-store stage: funct3 widths,
// default MMIO addresses and the byte-lane count of a 32-bit word.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [11:0] TOHOST_ADDR_DEF = 12'hFFC;
    localparam logic [11:0] CYCLE_ADDR_DEF  = 12'hFF8;

    localparam int LANES = 4;

endpackage

// File: rtl/dmem_lsu_if.sv
// Core <-> load/store stage bus: address, store data, strobes and width in;
// formatted load data and the combinational misalign flag out.
interface dmem_lsu_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_wdata;
    logic              i_ld;
    logic              i_sw;
    logic [2:0]        i_funct3;
    logic [31:0]       o_rdata;
    logic              o_misalign;

    modport master (
        output i_addr, i_wdata, i_ld, i_sw, i_funct3,
        input  o_rdata, o_misalign
    );

    modport slave (
        input  i_addr, i_wdata, i_ld, i_sw, i_funct3,
        output o_rdata, o_misalign
    );
endinterface

// File: rtl/dmem_load_fmt.sv
// Combinational load formatter: picks the byte/halfword lane out of a raw
// word and sign- or zero-extends it; flags misaligned or illegal widths.
module dmem_load_fmt
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        bad
);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign byte_s = 8'(word >> {lane, 3'b000});
    assign half_s = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = '0;
        bad  = 1'b0;
        case (funct3)
            F3_B:  data = 32'(byte_s);
            F3_BU: data = {24'd0, byte_s};
            F3_H:  if (lane[0]) bad = 1'b1; else data = 32'(half_s);
            F3_HU: if (lane[0]) bad = 1'b1; else data = {16'd0, half_s};
            F3_W:  if (lane != 2'd0) bad = 1'b1; else data = word;
            default: bad = 1'b1;
        endcase
    end
endmodule

// File: rtl/dmem_lsu.sv
// Data memory and load/store stage for the single-cycle RV32I core.
// `define DMEM_MMIO_EN adds the tohost/halt register and the cycle counter.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int              ADDR_W      = 12,
    parameter int              DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = TOHOST_ADDR_DEF,
    parameter logic [ADDR_W-1:0] CYCLE_ADDR  = CYCLE_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    dmem_lsu_if.slave   bus,
    output logic        o_fault,
    output logic        o_halt,
    output logic [31:0] o_tohost
);
    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        lane;
    logic [2:0]        f3;
    logic [31:0]       ram [DEPTH];
    logic [31:0]       rd_word;
    logic [31:0]       wr_word;
    logic [31:0]       ld_data;
    logic [LANES-1:0]  wr_mask;
    logic              ld_bad, st_bad, misalign;
    logic              halted, st_ok, ram_we, mmio_hit;

    assign word_idx = bus.i_addr[ADDR_W-1:2];
    assign lane     = bus.i_addr[1:0];
    assign f3       = bus.i_funct3;

    // Store data is replicated across lanes so the mask alone selects the target bytes.
    always_comb begin
        wr_mask = '0;
        wr_word = bus.i_wdata;
        st_bad  = 1'b0;
        case (f3)
            F3_B: begin
                wr_mask = LANES'(1) << lane;
                wr_word = {4{bus.i_wdata[7:0]}};
            end
            F3_H: begin
                wr_mask = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{bus.i_wdata[15:0]}};
                st_bad  = lane[0];
            end
            F3_W: begin
                wr_mask = 4'b1111;
                st_bad  = (lane != 2'd0);
            end
            default: st_bad = 1'b1;
        endcase
    end

    dmem_load_fmt u_fmt (
        .word   (rd_word),
        .lane   (lane),
        .funct3 (f3),
        .data   (ld_data),
        .bad    (ld_bad)
    );

    // A simultaneous store wins: width checks follow the store and the load is dropped.
    assign misalign       = bus.i_sw ? st_bad : (bus.i_ld & ld_bad);
    assign bus.o_misalign = misalign;
    assign bus.o_rdata    = (bus.i_ld & ~bus.i_sw) ? ld_data : '0;
    assign st_ok          = bus.i_sw & ~st_bad & ~halted;
    assign ram_we         = st_ok & ~mmio_hit;

`ifdef DMEM_MMIO_EN
    logic [31:0] cycle_q;
    logic        is_tohost, is_cycle;

    assign is_tohost = (word_idx == TOHOST_ADDR[ADDR_W-1:2]);
    assign is_cycle  = (word_idx == CYCLE_ADDR[ADDR_W-1:2]);
    assign mmio_hit  = is_tohost | is_cycle;
    assign halted    = o_halt;
    assign rd_word   = is_tohost ? o_tohost : (is_cycle ? cycle_q : ram[word_idx]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_halt   <= 1'b0;
            o_tohost <= '0;
            cycle_q  <= '0;
        end else begin
            if (!o_halt)
                cycle_q <= cycle_q + 32'd1;
            if (st_ok && is_tohost && f3 == F3_W) begin
                o_halt   <= 1'b1;
                o_tohost <= bus.i_wdata;
            end
        end
    end
`else
    assign mmio_hit = 1'b0;
    assign halted   = 1'b0;
    assign rd_word  = ram[word_idx];
    assign o_halt   = 1'b0;
    assign o_tohost = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            o_fault <= 1'b0;
        else if (misalign)
            o_fault <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < LANES; b++)
                if (wr_mask[b])
                    ram[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed scenarios plus randomized traffic
// against a byte-addressed reference model. MMIO scenarios follow DMEM_MMIO_EN.
`timescale 1ns/1ps
module tb_dmem_lsu;
`ifdef DMEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        o_fault, o_halt;
    logic [31:0] o_tohost;
    int          checks = 0;
    int          errors = 0;

    logic [7:0]  mb [4096];
    logic        m_fault, m_halt;
    logic [31:0] m_tohost, m_ctr;
    logic        c_ld, c_sw;
    logic [2:0]  c_f3;
    logic [11:0] c_addr;
    logic [31:0] c_wd;

    dmem_lsu_if #(.ADDR_W(12)) bus ();

    dmem_lsu dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .o_fault  (o_fault),
        .o_halt   (o_halt),
        .o_tohost (o_tohost)
    );

    always #5 clk = ~clk;

    function automatic logic m_bad(input logic ld, input logic sw, input logic [2:0] f3, input logic [11:0] a);
        int  size;
        logic illegal;
        if (!ld && !sw) return 1'b0;
        if (sw) illegal = (f3 >= 3'd3);
        else    illegal = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if (illegal) return 1'b1;
        size = 1 << f3[1:0];
        return (int'(a) % size) != 0;
    endfunction

    function automatic logic [31:0] m_raw(input logic [11:0] a);
        int base;
        base = (int'(a) / 4) * 4;
        if (MMIO && base == 'hFFC) return m_tohost;
        if (MMIO && base == 'hFF8) return m_ctr;
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    endfunction

    function automatic logic [31:0] m_rdata(input logic ld, input logic sw, input logic [2:0] f3, input logic [11:0] a);
        int size, sh;
        logic [31:0] v, mask;
        if (!ld || sw || m_bad(ld, sw, f3, a)) return 32'd0;
        size = 1 << f3[1:0];
        sh   = 8 * (int'(a) % 4);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
        v    = (m_raw(a) >> sh) & mask;
        if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic apply(input logic ld, input logic sw, input logic [2:0] f3,
                         input logic [11:0] a, input logic [31:0] wd);
        @(negedge clk);
        c_ld = ld; c_sw = sw; c_f3 = f3; c_addr = a; c_wd = wd;
        bus.i_ld = ld; bus.i_sw = sw; bus.i_funct3 = f3; bus.i_addr = a; bus.i_wdata = wd;
        #1;
    endtask

    // Advance the model by one clock with the currently applied inputs, then let the DUT clock.
    task automatic commit();
        int   base, size;
        logic bad, was_halted;
        bad        = m_bad(c_ld, c_sw, c_f3, c_addr);
        was_halted = m_halt;
        base       = (int'(c_addr) / 4) * 4;
        if (bad) m_fault = 1'b1;
        if (c_sw && !bad && !was_halted) begin
            if (MMIO && base == 'hFFC) begin
                if (c_f3 == 3'd2) begin
                    m_tohost = c_wd;
                    m_halt   = 1'b1;
                end
            end else if (!(MMIO && base == 'hFF8)) begin
                size = 1 << c_f3[1:0];
                for (int k = 0; k < size; k++) mb[int'(c_addr) + k] = c_wd[8*k +: 8];
            end
        end
        if (!was_halted) m_ctr = m_ctr + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        c_ld = 1'b0; c_sw = 1'b0; c_f3 = 3'd0; c_addr = 12'h000; c_wd = 32'd0;
        bus.i_ld = 1'b0; bus.i_sw = 1'b0; bus.i_funct3 = 3'd0; bus.i_addr = 12'h000; bus.i_wdata = 32'd0;
        m_fault = 1'b0; m_halt = 1'b0; m_tohost = 32'd0; m_ctr = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (o_fault !== 1'b0)     begin errors++; $display("FAIL reset_fault got=%b want=0", o_fault); end
        checks++; if (o_halt !== 1'b0)      begin errors++; $display("FAIL reset_halt got=%b want=0", o_halt); end
        checks++; if (o_tohost !== 32'd0)   begin errors++; $display("FAIL reset_tohost got=%h want=0", o_tohost); end
        checks++; if (bus.o_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h want=0", bus.o_rdata); end
        checks++; if (bus.o_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b want=0", bus.o_misalign); end
        @(negedge clk);
        reset = 1'b1;
        commit();
    endtask

    task automatic test_load_formats();
        logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd2};
        logic [11:0] adrs [4] = '{12'h011, 12'h011, 12'h012, 12'h010};
        logic [31:0] exps [4] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h8899_AABB};
        apply(1'b0, 1'b1, 3'd2, 12'h010, 32'h8899_AABB); commit();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, f3s[i], adrs[i], 32'd0);
            checks++;
            if (bus.o_rdata !== exps[i]) begin
                errors++; $display("FAIL load_fmt[%0d] got=%h want=%h", i, bus.o_rdata, exps[i]);
            end
            commit();
        end
    endtask

    task automatic test_store_masks();
        apply(1'b0, 1'b1, 3'd2, 12'h020, 32'h0000_0000); commit();
        apply(1'b0, 1'b1, 3'd0, 12'h023, 32'h0000_005A); commit();
        apply(1'b0, 1'b1, 3'd1, 12'h020, 32'h0000_1234); commit();
        apply(1'b1, 1'b0, 3'd2, 12'h020, 32'd0);
        checks++; if (bus.o_rdata !== 32'h5A00_1234) begin errors++; $display("FAIL store_mask got=%h want=%h", bus.o_rdata, 32'h5A00_1234); end
        commit();
    endtask

    task automatic test_misalign();
        apply(1'b0, 1'b1, 3'd2, 12'h030, 32'h1111_1111); commit();
        apply(1'b0, 1'b1, 3'd2, 12'h031, 32'hDEAD_BEEF);
        checks++; if (bus.o_misalign !== 1'b1) begin errors++; $display("FAIL sw_misalign got=%b want=1", bus.o_misalign); end
        checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL fault_early got=%b want=0", o_fault); end
        commit();
        checks++; if (o_fault !== 1'b1) begin errors++; $display("FAIL fault_set got=%b want=1", o_fault); end
        apply(1'b1, 1'b0, 3'd2, 12'h030, 32'd0);
        checks++; if (bus.o_rdata !== 32'h1111_1111) begin errors++; $display("FAIL misaligned_no_write got=%h want=%h", bus.o_rdata, 32'h1111_1111); end
        commit();
        apply(1'b1, 1'b0, 3'd1, 12'h013, 32'd0);
        checks++; if (bus.o_rdata !== 32'd0) begin errors++; $display("FAIL lh_misal_rdata got=%h want=0", bus.o_rdata); end
        checks++; if (bus.o_misalign !== 1'b1) begin errors++; $display("FAIL lh_misal_flag got=%b want=1", bus.o_misalign); end
        commit();
        apply(1'b1, 1'b0, 3'd6, 12'h010, 32'd0);
        checks++; if (bus.o_misalign !== 1'b1) begin errors++; $display("FAIL illegal_ld got=%b want=1", bus.o_misalign); end
        commit();
        repeat (3) begin apply(1'b0, 1'b0, 3'd0, 12'h000, 32'd0); commit(); end
        checks++; if (o_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got=%b want=1", o_fault); end
    endtask

    task automatic test_ld_sw_both();
        apply(1'b1, 1'b1, 3'd2, 12'h050, 32'hCAFE_F00D);
        checks++; if (bus.o_rdata !== 32'd0) begin errors++; $display("FAIL both_rdata got=%h want=0", bus.o_rdata); end
        checks++; if (bus.o_misalign !== 1'b0) begin errors++; $display("FAIL both_misalign got=%b want=0", bus.o_misalign); end
        commit();
        apply(1'b1, 1'b0, 3'd2, 12'h050, 32'd0);
        checks++; if (bus.o_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL both_write got=%h want=%h", bus.o_rdata, 32'hCAFE_F00D); end
        commit();
        apply(1'b1, 1'b1, 3'd4, 12'h060, 32'h0000_0001);
        checks++; if (bus.o_misalign !== 1'b1) begin errors++; $display("FAIL both_store_width got=%b want=1", bus.o_misalign); end
        commit();
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_counter();
        apply(1'b1, 1'b0, 3'd2, 12'hFF8, 32'd0);
        checks++; if (bus.o_rdata !== m_ctr) begin errors++; $display("FAIL cycle_read got=%h want=%h", bus.o_rdata, m_ctr); end
        commit();
        apply(1'b0, 1'b1, 3'd2, 12'hFF8, 32'h5555_0000); commit();
        apply(1'b1, 1'b0, 3'd2, 12'hFF8, 32'd0);
        checks++; if (bus.o_rdata !== m_ctr) begin errors++; $display("FAIL cycle_store_drop got=%h want=%h", bus.o_rdata, m_ctr); end
        commit();
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        m_ctr = 32'hFFFF_FFFF;
        apply(1'b0, 1'b0, 3'd0, 12'h000, 32'd0); commit();
        apply(1'b1, 1'b0, 3'd2, 12'hFF8, 32'd0);
        checks++; if (bus.o_rdata !== 32'd0) begin errors++; $display("FAIL cycle_wrap got=%h want=0", bus.o_rdata); end
        commit();
    endtask

    task automatic test_halt();
        apply(1'b0, 1'b1, 3'd2, 12'h040, 32'h1234_5678); commit();
        apply(1'b0, 1'b1, 3'd0, 12'hFFC, 32'h0000_00AB);
        checks++; if (bus.o_misalign !== 1'b0) begin errors++; $display("FAIL sb_tohost_flag got=%b want=0", bus.o_misalign); end
        commit();
        checks++; if (o_halt !== 1'b0) begin errors++; $display("FAIL sb_tohost_halt got=%b want=0", o_halt); end
        apply(1'b0, 1'b1, 3'd2, 12'hFFC, 32'h0000_0001); commit();
        checks++; if (o_halt !== 1'b1) begin errors++; $display("FAIL halt_set got=%b want=1", o_halt); end
        checks++; if (o_tohost !== 32'h1) begin errors++; $display("FAIL tohost_val got=%h want=1", o_tohost); end
        apply(1'b0, 1'b1, 3'd2, 12'h040, 32'h0000_0077); commit();
        apply(1'b1, 1'b0, 3'd2, 12'h040, 32'd0);
        checks++; if (bus.o_rdata !== 32'h1234_5678) begin errors++; $display("FAIL halt_suppress got=%h want=%h", bus.o_rdata, 32'h1234_5678); end
        commit();
        apply(1'b1, 1'b0, 3'd2, 12'hFFC, 32'd0);
        checks++; if (bus.o_rdata !== 32'h1) begin errors++; $display("FAIL tohost_read got=%h want=1", bus.o_rdata); end
        commit();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b0, 3'd2, 12'hFF8, 32'd0);
            checks++; if (bus.o_rdata !== m_ctr) begin errors++; $display("FAIL cycle_frozen[%0d] got=%h want=%h", i, bus.o_rdata, m_ctr); end
            commit();
        end
    endtask
`endif

    task automatic test_reset_midrun();
        apply(1'b1, 1'b0, 3'd2, 12'h010, 32'd0);
        reset = 1'b0;
        m_fault = 1'b0; m_halt = 1'b0; m_tohost = 32'd0; m_ctr = 32'd0;
        #0.5;
        checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL midrst_fault got=%b want=0", o_fault); end
        checks++; if (o_halt !== 1'b0)  begin errors++; $display("FAIL midrst_halt got=%b want=0", o_halt); end
        checks++; if (o_tohost !== 32'd0) begin errors++; $display("FAIL midrst_tohost got=%h want=0", o_tohost); end
        checks++; if (bus.o_rdata !== 32'h8899_AABB) begin errors++; $display("FAIL midrst_ram got=%h want=%h", bus.o_rdata, 32'h8899_AABB); end
`ifdef DMEM_MMIO_EN
        c_addr = 12'hFF8; bus.i_addr = 12'hFF8;
        #0.5;
        checks++; if (bus.o_rdata !== 32'd0) begin errors++; $display("FAIL midrst_cycle got=%h want=0", bus.o_rdata); end
`endif
        reset = 1'b1;
        commit();
        apply(1'b1, 1'b0, 3'd2, 12'h020, 32'd0);
        checks++; if (bus.o_rdata !== 32'h5A00_1234) begin errors++; $display("FAIL midrst_ram2 got=%h want=%h", bus.o_rdata, 32'h5A00_1234); end
        commit();
        checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL midrst_fault2 got=%b want=0", o_fault); end
    endtask

    task automatic test_random();
        logic [31:0] exp_rd;
        logic        exp_mis;
        for (int w = 0; w < 64; w++) begin
            apply(1'b0, 1'b1, 3'd2, 12'(w * 4), $urandom); commit();
        end
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom % 2), 1'($urandom % 4 == 0), 3'($urandom % 8), 12'($urandom % 256), $urandom);
            exp_rd  = m_rdata(c_ld, c_sw, c_f3, c_addr);
            exp_mis = m_bad(c_ld, c_sw, c_f3, c_addr);
            checks++;
            if (bus.o_rdata !== exp_rd) begin
                errors++; $display("FAIL rand_rdata[%0d] ld=%b sw=%b f3=%0d a=%h got=%h want=%h", i, c_ld, c_sw, c_f3, c_addr, bus.o_rdata, exp_rd);
            end
            checks++;
            if (bus.o_misalign !== exp_mis) begin
                errors++; $display("FAIL rand_misalign[%0d] ld=%b sw=%b f3=%0d a=%h got=%b want=%b", i, c_ld, c_sw, c_f3, c_addr, bus.o_misalign, exp_mis);
            end
            commit();
            checks++;
            if (o_fault !== m_fault) begin
                errors++; $display("FAIL rand_fault[%0d] got=%b want=%b", i, o_fault, m_fault);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_formats();
        test_store_masks();
        test_misalign();
        test_ld_sw_both();
`ifdef DMEM_MMIO_EN
        test_counter();
        test_halt();
`endif
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
